sort_stream_adapter: RTL and testbench

Streaming front/back end for the combinational N-word sorter. It collects N serial words from a valid/ready input into a frame register and presents that frame to the sorter's `data_in` bus. After the frame has settled, it captures the sorter's `data_sorted` bus into an output buffer and drains the buffer serially on a valid/ready output. Filling the next frame overlaps with draining the current one, so a continuous sample stream can pass through the sorter.

---
 rtl/sort_stream_adapter.sv | 126 ++++++++++++
 tb/tb_sort_stream_adapter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_adapter.sv
// rtl/sort_stream_adapter.sv - serial-to-frame front end and frame-to-serial back end for a combinational N-word sorter
// Optional ordering check on captured results enabled by `define SORT_ADAPTER_CHECK_EN.
module sort_stream_adapter #(
    parameter int N     = 6,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] frame_out [N],
    input  logic [WIDTH-1:0] sorted_in [N],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             sort_err
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]       fill_state;
    logic [0:0]       drain_state;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic             settled;
    logic [WIDTH-1:0] obuf [N];

    logic in_fire;
    logic out_fire;
    logic capture;

    assign in_fire   = in_valid && in_ready;
    assign out_valid = (drain_state == DRAIN);
    assign out_last  = out_valid && (rd_idx == LAST_IDX);
    assign out_data  = obuf[rd_idx];
    assign out_fire  = out_valid && out_ready;

    // A new frame may replace obuf only once the previous one is gone or leaving this cycle.
    assign capture = (fill_state == FULL) && settled &&
                     ((drain_state == IDLE) || (out_fire && out_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_state <= FILL;
            wr_idx     <= '0;
            in_ready   <= 1'b0;
            settled    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                frame_out[i] <= '0;
            end
        end else if (capture) begin
            fill_state <= FILL;
            settled    <= 1'b0;
            in_ready   <= 1'b1;
        end else if (fill_state == FILL) begin
            in_ready <= 1'b1;
            if (in_fire) begin
                frame_out[wr_idx] <= in_data;
                if (wr_idx == LAST_IDX) begin
                    // frame_out is frozen from here on, so the sorter has the whole next cycle to settle
                    wr_idx     <= '0;
                    fill_state <= FULL;
                    settled    <= 1'b1;
                    in_ready   <= 1'b0;
                end else begin
                    wr_idx <= wr_idx + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_state <= IDLE;
            rd_idx      <= '0;
            for (int i = 0; i < N; i++) begin
                obuf[i] <= '0;
            end
        end else if (capture) begin
            drain_state <= DRAIN;
            rd_idx      <= '0;
            for (int i = 0; i < N; i++) begin
                obuf[i] <= sorted_in[i];
            end
        end else if (out_fire) begin
            if (out_last) begin
                drain_state <= IDLE;
                rd_idx      <= '0;
            end else begin
                rd_idx <= rd_idx + IW'(1);
            end
        end
    end

`ifdef SORT_ADAPTER_CHECK_EN
    logic order_viol;

    always_comb begin
        order_viol = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if (sorted_in[i] > sorted_in[i + 1]) begin
                order_viol = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sort_err <= 1'b0;
        end else if (capture && order_viol) begin
            sort_err <= 1'b1;
        end
    end
`else
    assign sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_stream_adapter.sv
// tb/tb_sort_stream_adapter.sv - directed self-checking bench for sort_stream_adapter with an ideal sorter model
module tb_sort_stream_adapter;

    localparam int N = 6;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] frame_out [N];
    logic [W-1:0] sorted_in [N];
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         sort_err;
    logic         bad_mode;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int exp_err;

    logic [W-1:0] oq [$];
    logic         lq [$];
    int           cq [$];

    logic [W-1:0] tmp [N];
    logic [W-1:0] swp;
    logic [W-1:0] snap [N];

    logic [W-1:0] fa  [N]  = '{8'd30, 8'd10, 8'd50, 8'd20, 8'd60, 8'd40};
    logic [W-1:0] fa_s [N] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    logic [W-1:0] fb  [N]  = '{8'd66, 8'd11, 8'd55, 8'd22, 8'd44, 8'd33};
    logic [W-1:0] fb_s [N] = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66};
    logic [W-1:0] bad [N]  = '{8'd10, 8'd30, 8'd20, 8'd40, 8'd50, 8'd60};
    logic [W-1:0] bb_in [24] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0,
                                 8'd200, 8'd100, 8'd150, 8'd250, 8'd50, 8'd0,
                                 8'd7, 8'd7, 8'd3, 8'd9, 8'd3, 8'd1,
                                 8'd255, 8'd128, 8'd64, 8'd32, 8'd16, 8'd8};
    logic [W-1:0] bb_s [24]  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5,
                                 8'd0, 8'd50, 8'd100, 8'd150, 8'd200, 8'd250,
                                 8'd1, 8'd3, 8'd3, 8'd7, 8'd7, 8'd9,
                                 8'd8, 8'd16, 8'd32, 8'd64, 8'd128, 8'd255};

    sort_stream_adapter #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .frame_out (frame_out),
        .sorted_in (sorted_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sort_err  (sort_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ideal sorter, or a fixed mis-ordered result when bad_mode is set
    always_comb begin
        swp = '0;
        for (int i = 0; i < N; i++) tmp[i] = frame_out[i];
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N - 1; j++) begin
                if (tmp[j] > tmp[j + 1]) begin
                    swp = tmp[j]; tmp[j] = tmp[j + 1]; tmp[j + 1] = swp;
                end
            end
        end
        for (int i = 0; i < N; i++) sorted_in[i] = bad_mode ? bad[i] : tmp[i];
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            oq.push_back(out_data);
            lq.push_back(out_last);
            cq.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_q();
        oq.delete(); lq.delete(); cq.delete();
    endtask

    task automatic send_word(input logic [W-1:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        last_hs_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        int t = 0;
        while (oq.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("out_count", oq.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int mis;
        int nlast;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; bad_mode = 1'b0;
`ifdef SORT_ADAPTER_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif

        // Reset asserted between edges
        #3 rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_frame0", frame_out[0], 0);
        check("rst_frame5", frame_out[5], 0);
        check("rst_sort_err", sort_err, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 check("rel_in_ready_before_edge", in_ready, 0);
        @(posedge clk); #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);

        // Single frame
        clear_q();
        for (int i = 0; i < N; i++) send_word(fa[i]);
        c = last_hs_cyc;
        check("single_in_ready_full", in_ready, 0);
        check("single_out_valid_c1", out_valid, 0);
        @(posedge clk); #1;
        check("single_out_valid_c2", out_valid, 1);
        check("single_in_ready_c2", in_ready, 1);
        wait_outputs(N);
        check("single_latency", cq[0] - c, 2);
        for (int i = 0; i < N; i++) begin
            check($sformatf("single_data%0d", i), oq[i], fa_s[i]);
            check($sformatf("single_last%0d", i), lq[i], (i == N - 1) ? 1 : 0);
        end

        // Backpressure with two frames supplied
        repeat (3) @(posedge clk); #1;
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send_word(fa[i]);
        for (int i = 0; i < N; i++) send_word(fb[i]);
        check("bp_in_ready_after12", in_ready, 0);
        for (int i = 0; i < N; i++) snap[i] = frame_out[i];
        repeat (20) @(posedge clk); #1;
        mis = 0;
        for (int i = 0; i < N; i++) if (frame_out[i] !== fb[i] || frame_out[i] !== snap[i]) mis++;
        check("bp_frame_stable", mis, 0);
        check("bp_in_ready_held", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_out_data_held", out_data, 10);
        check("bp_out_last_held", out_last, 0);
        check("bp_no_output", oq.size(), 0);
        out_ready = 1'b1;
        wait_outputs(2 * N);
        for (int i = 0; i < 2 * N; i++) begin
            check($sformatf("bp_data%0d", i), oq[i], (i < N) ? fa_s[i] : fb_s[i - N]);
            check($sformatf("bp_last%0d", i), lq[i], (i % N == N - 1) ? 1 : 0);
        end
        check("bp_no_bubble", cq[N] - cq[N - 1], 1);

        // Back-to-back frames
        repeat (3) @(posedge clk); #1;
        clear_q();
        for (int i = 0; i < 24; i++) send_word(bb_in[i]);
        wait_outputs(24);
        repeat (12) @(posedge clk); #1;
        check("bb_no_dup", oq.size(), 24);
        for (int i = 0; i < 24; i++) begin
            check($sformatf("bb_data%0d", i), oq[i], bb_s[i]);
            check($sformatf("bb_last%0d", i), lq[i], (i % N == N - 1) ? 1 : 0);
        end

        // Reset in the middle of traffic
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send_word(fa[i]);
        for (int i = 0; i < 3; i++) send_word(fb[i]);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("mid_two_out", oq.size(), 2);
        check("mid_two_data", oq[1], 20);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_frame2", frame_out[2], 0);
        clear_q();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (20) @(posedge clk); #1;
        check("mid_no_output", oq.size(), 0);
        for (int i = 0; i < N; i++) send_word(fb[i]);
        wait_outputs(N);
        repeat (10) @(posedge clk); #1;
        check("mid_exact6", oq.size(), N);
        nlast = 0;
        for (int i = 0; i < oq.size(); i++) begin
            check($sformatf("mid_data%0d", i), oq[i], fb_s[i]);
            if (lq[i]) nlast++;
        end
        check("mid_one_last", nlast, 1);
        check("mid_last_pos", lq[N - 1], 1);

        // Mis-ordered sorter result
        clear_q();
        bad_mode = 1'b1;
        for (int i = 0; i < N; i++) send_word(fa[i]);
        check("err_before_capture", sort_err, 0);
        @(posedge clk); #1;
        check("err_after_capture", sort_err, exp_err);
        wait_outputs(N);
        for (int i = 0; i < N; i++) check($sformatf("err_data%0d", i), oq[i], bad[i]);
        bad_mode = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("err_sticky", sort_err, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
